out_frame_streamer: RTL and testbench

- Reader for the output SRAM that the FAST/draw-circle pipeline writes: once the frame is complete, it walks the output image in raster order and issues one read per pixel.
- It returns each 24-bit RGB pixel over a valid/ready stream to the display/DMA side.
- It holds a 2-entry skid FIFO so that SRAM read latency and downstream back-pressure are absorbed without dropping or duplicating pixels.
- It sits after fast_top_level; its start input is driven by that block's done.

---
 rtl/out_frame_streamer_if.sv | 20 ++
 rtl/out_frame_streamer.sv | 92 +++++++++
 tb/tb_out_frame_streamer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/out_frame_streamer_if.sv
// out_frame_streamer_if: output-SRAM read port and the 24-bit pixel stream.
interface out_frame_streamer_if #(parameter int AW = 3);
  logic        read_SRAM_OUT;
  logic [AW:0] x_addr_OUT;
  logic [AW:0] y_addr_OUT;
  logic [23:0] SRAM_OUT_rdata;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_eol;
  logic        pix_last;
  modport master (
    output read_SRAM_OUT, x_addr_OUT, y_addr_OUT, pix_data, pix_valid, pix_eol, pix_last,
    input  SRAM_OUT_rdata, pix_ready
  );
  modport slave (
    input  read_SRAM_OUT, x_addr_OUT, y_addr_OUT, pix_data, pix_valid, pix_eol, pix_last,
    output SRAM_OUT_rdata, pix_ready
  );
endinterface

// File: rtl/out_frame_streamer.sv
// out_frame_streamer: raster-order reader of the output SRAM, streaming pixels through a 2-entry skid FIFO.
module out_frame_streamer #(
  parameter int X_MAX = 5,
  parameter int Y_MAX = 5
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start,
  input  logic [$clog2(X_MAX)-1:0] max_x,
  input  logic [$clog2(X_MAX)-1:0] max_y,
  output logic                     busy,
  output logic                     done,
  out_frame_streamer_if.master     bus
);
  localparam int AW = $clog2(X_MAX);
  localparam logic [AW-1:0] XLIM = AW'(X_MAX - 1);
  localparam logic [AW-1:0] YLIM = AW'(Y_MAX - 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] mx_q, mx_d, my_q, my_d, x_q, x_d, y_q, y_d;
  logic          infl_q, eol_q, last_q;
  logic [25:0]   mem_q [2];
  logic          rptr_q, rptr_d, wptr_q, wptr_d;
  logic [1:0]    cnt_q, cnt_d, occ;
  logic          go, rd, pop, at_eol, at_last;
  // occ is what the FIFO will hold after this edge if no new read is issued
  always_comb begin
    pop     = bus.pix_valid && bus.pix_ready;
    occ     = cnt_q + {1'b0, infl_q} - {1'b0, pop};
    go      = state_q == IDLE && start;
    rd      = state_q == RUN && occ < 2'd2;
    at_eol  = x_q == mx_q;
    at_last = at_eol && y_q == my_q;
  end
  always_comb begin
    state_d = go ? RUN :
              (state_q == RUN && rd && at_last) ? DRAIN :
              (state_q == DRAIN && occ == 2'd0) ? DONE :
              (state_q == DONE) ? IDLE : state_q;
    mx_d    = go ? ((max_x > XLIM) ? XLIM : max_x) : mx_q;
    my_d    = go ? ((max_y > YLIM) ? YLIM : max_y) : my_q;
    x_d     = go ? '0 : rd ? (at_eol ? '0 : x_q + 1'b1) : x_q;
    y_d     = go ? '0 : (rd && at_eol && !at_last) ? y_q + 1'b1 : y_q;
    cnt_d   = cnt_q + {1'b0, infl_q} - {1'b0, pop};
    rptr_d  = rptr_q ^ pop;
    wptr_d  = wptr_q ^ infl_q;
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      mx_q     <= '0;
      my_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      infl_q   <= 1'b0;
      eol_q    <= 1'b0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      rptr_q   <= 1'b0;
      wptr_q   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      state_q <= state_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      x_q     <= x_d;
      y_q     <= y_d;
      infl_q  <= rd;
      eol_q   <= at_eol;
      last_q  <= at_last;
      cnt_q   <= cnt_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      if (infl_q) mem_q[wptr_q] <= {last_q, eol_q, bus.SRAM_OUT_rdata};
    end
  end
  always_comb begin
    bus.read_SRAM_OUT = rd;
    bus.x_addr_OUT    = {1'b0, x_q};
    bus.y_addr_OUT    = {1'b0, y_q};
    bus.pix_valid     = cnt_q != 2'd0;
    bus.pix_data      = mem_q[rptr_q][23:0];
    bus.pix_eol       = mem_q[rptr_q][24];
    bus.pix_last      = mem_q[rptr_q][25];
    busy              = state_q != IDLE;
    done              = state_q == DONE;
  end
endmodule

// File: tb/tb_out_frame_streamer.sv
// tb_out_frame_streamer: directed and randomized frames checked against a raster-order beat model.
module tb_out_frame_streamer;
  localparam int X_MAX = 5;
  localparam int Y_MAX = 5;
  localparam int AW = $clog2(X_MAX);
  typedef struct {
    logic [23:0] d;
    logic        eol;
    logic        last;
  } beat_t;
  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] max_x = '0;
  logic [AW-1:0] max_y = '0;
  logic          busy, done;
  logic [7:0]    salt = 8'hA5;
  int            vectors = 0;
  int            miscompares = 0;
  beat_t         exp_q[$];
  int            addr_q[$];
  out_frame_streamer_if #(.AW(AW)) bus();
  out_frame_streamer #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .max_x(max_x), .max_y(max_y),
    .busy(busy), .done(done), .bus(bus)
  );
  always #5 clk = ~clk;
  // SRAM model: one-cycle latency, garbage whenever no read was issued
  always @(posedge clk)
    bus.SRAM_OUT_rdata <= bus.read_SRAM_OUT ? {8'(bus.y_addr_OUT), 8'(bus.x_addr_OUT), salt} : 24'($urandom);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic build(input int mx, input int my);
    exp_q.delete();
    addr_q.delete();
    for (int y = 0; y <= my; y++)
      for (int x = 0; x <= mx; x++) begin
        exp_q.push_back('{d: {8'(y), 8'(x), salt}, eol: x == mx, last: x == mx && y == my});
        addr_q.push_back(y * 16 + x);
      end
  endtask
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ctl"}, {bus.read_SRAM_OUT, bus.x_addr_OUT, bus.y_addr_OUT, bus.pix_valid,
                        bus.pix_eol, bus.pix_last, busy, done}, 32'h0);
    chk({tag, "_data"}, bus.pix_data, 32'h0);
  endtask
  // mode: 0 ready high, 1 pattern 1,0,0,1,0,1, 2 random, 3 low for the first 10 cycles
  task automatic frame(input int mx, input int my, input int mode, input int rst_beat, input int restart_cyc);
    int    pat[6] = '{1, 0, 0, 1, 0, 1};
    int    reads = 0, beats = 0, total, done_cyc = -1;
    logic  last_hs = 1'b0, stalled = 1'b0, finished = 1'b0;
    logic [25:0] held = '0;
    beat_t e;
    build(mx, my);
    total = exp_q.size();
    @(negedge clk);
    max_x = AW'(mx);
    max_y = AW'(my);
    start = 1'b1;
    for (int cyc = 1; cyc < 3000 && !finished; cyc++) begin
      @(negedge clk);
      start = cyc == restart_cyc;
      max_x = AW'($urandom);
      max_y = AW'($urandom);
      bus.pix_ready = mode == 0 ? 1'b1 : mode == 1 ? pat[(cyc - 1) % 6] != 0 :
                      mode == 2 ? $urandom_range(0, 3) != 0 : cyc > 10;
      #1;
      chk("done", done, last_hs);
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("busy_after", busy, 0);
        chk("beats_total", beats, total);
        chk("reads_total", reads, total);
        finished = 1'b1;
      end else
        chk("busy", busy, 1);
      if (last_hs) done_cyc = cyc;
      last_hs = 1'b0;
      if (stalled) begin
        chk("stall_valid", bus.pix_valid, 1);
        chk("stall_hold", {bus.pix_last, bus.pix_eol, bus.pix_data}, held);
      end
      if (bus.read_SRAM_OUT) begin
        chk("read_addr", {bus.y_addr_OUT, bus.x_addr_OUT}, addr_q.size() != 0 ? addr_q.pop_front() : 32'hFFFF_FFFF);
        reads++;
      end
      if (mode == 3 && cyc == 10) begin
        chk("bp_reads", reads, 2);
        chk("bp_valid", bus.pix_valid, 1);
        chk("bp_head", bus.pix_data, exp_q.size() != 0 ? exp_q[0].d : 24'hFFFFFF);
      end
      if (bus.pix_valid && bus.pix_ready) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat", {bus.pix_last, bus.pix_eol, bus.pix_data}, {e.last, e.eol, e.d});
        end else
          chk("extra_beat", {bus.pix_last, bus.pix_eol, bus.pix_data}, 32'hFFFF_FFFF);
        beats++;
        last_hs = beats == total;
      end
      chk("outstanding", (reads - beats) <= 2, 1);
      stalled = bus.pix_valid && !bus.pix_ready;
      held = {bus.pix_last, bus.pix_eol, bus.pix_data};
      if (rst_beat != 0 && beats == rst_beat) finished = 1'b1;
    end
    start = 1'b0;
    chk("frame_timeout", finished, 1);
  endtask
  initial begin
    bus.pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    n_rst = 1'b1;
    frame(2, 1, 0, 0, 0);
    frame(2, 1, 1, 0, 0);
    frame(0, 0, 0, 0, 0);
    frame(3, 3, 3, 0, 0);
    salt = 8'h3C;
    frame(3, 3, 0, 3, 4);
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    #1;
    check_idle_outputs("midframe_rst");
    n_rst = 1'b1;
    frame(3, 3, 0, 0, 0);
    repeat (6) begin
      salt = 8'($urandom);
      frame($urandom_range(0, 4), $urandom_range(0, 4), 2, 0, $urandom_range(2, 8));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
